// File: rtl/clkdiv_bank_pkg.sv
// rtl/clkdiv_bank_pkg.sv - shared types, constants and helpers for the clock divider bank
package clkdiv_pkg;

    typedef enum logic {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    localparam int MIN_DIV = 2;

    // High phase length; odd divisors spend the extra cycle high.
    function automatic int unsigned high_len(input int unsigned div);
        return (div + 1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_bank_if.sv
// rtl/clkdiv_bank_if.sv - control and output bundle of the clock divider bank
interface clkdiv_bank_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en_in;
    logic              load_in;
    logic [CH_W-1:0]   load_ch_in;
    logic [CNT_W-1:0]  load_div_in;
    logic              sync_in;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick_out;
    logic              err_out;

    modport master (
        output en_in, load_in, load_ch_in, load_div_in, sync_in,
        input  clk_out, tick_out, err_out
    );

    modport slave (
        input  en_in, load_in, load_ch_in, load_div_in, sync_in,
        output clk_out, tick_out, err_out
    );

endinterface

// File: rtl/clkdiv_channel.sv
// rtl/clkdiv_channel.sv - one programmable divider with glitch-free stop and deferred reload
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(10)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load_strobe,
    input  logic [CNT_W-1:0] load_div,
    output logic             clk_div,
    output logic             tick
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] eff_div;
    logic [CNT_W-1:0] cnt_inc;
    logic             wrap;

    // A same-cycle load beats an older pending value, so the last load wins.
    assign eff_div = load_strobe ? load_div : (pend_q ? pdiv_q : div_q);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign wrap    = (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        case (state_q)
            CH_STOP: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (load_strobe) begin
                    div_d  = load_div;
                    pend_d = 1'b0;
                end
                if (en) begin
                    state_d = CH_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            CH_RUN: begin
                if (sync || wrap) begin
                    cnt_d  = '0;
                    div_d  = eff_div;
                    pend_d = 1'b0;
                    // Stopping only at a wrap keeps the low phase intact; sync restarts instead.
                    if (!sync && !en) begin
                        state_d = CH_STOP;
                        clk_d   = 1'b0;
                    end else begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (32'(cnt_inc) < high_len(32'(div_q)));
                    if (load_strobe) begin
                        pend_d = 1'b1;
                        pdiv_d = load_div;
                    end
                end
            end
            default: begin
                state_d = CH_STOP;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_STOP;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pdiv_q  <= '0;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_div = clk_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clkdiv_bank.sv
// rtl/clkdiv_bank.sv - bank of programmable clock dividers with shared load bus and sync
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int                      NUM_CH   = 2,
    parameter int                      CNT_W    = 8,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd100, 8'd10}
) (
    input  logic        clock_1MHz,
    input  logic        rst,
    clkdiv_bank_if.slave bus
);

    logic              load_ok;
    logic              err_q;
    logic [NUM_CH-1:0] strobe;
    logic [NUM_CH-1:0] clk_vec;
    logic [NUM_CH-1:0] tick_vec;

    assign load_ok = (32'(bus.load_div_in) >= 32'(MIN_DIV)) &&
                     (32'(bus.load_ch_in) < 32'(NUM_CH));

    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.load_in && !load_ok) begin
            err_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        if (DIV_INIT[g*CNT_W +: CNT_W] < CNT_W'(MIN_DIV)) begin : g_bad_init
            $error("clkdiv_bank: DIV_INIT entry %0d is below MIN_DIV", g);
        end

        assign strobe[g] = bus.load_in && load_ok && (32'(bus.load_ch_in) == 32'(g));

        clkdiv_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk         (clock_1MHz),
            .rst         (rst),
            .en          (bus.en_in[g]),
            .sync        (bus.sync_in),
            .load_strobe (strobe[g]),
            .load_div    (bus.load_div_in),
            .clk_div     (clk_vec[g]),
            .tick        (tick_vec[g])
        );
    end

    assign bus.clk_out  = clk_vec;
    assign bus.tick_out = tick_vec;
    assign bus.err_out  = err_q;

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb/tb_clkdiv_bank.sv - self-checking bench for clkdiv_bank with cycle scoreboard
module tb_clkdiv_bank;

    localparam int NC = 3;

    typedef struct {
        logic [NC-1:0] clk;
        logic [NC-1:0] tick;
        logic          err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    int   m_init[NC] = '{10, 100, 3};
    int   m_run[NC], m_cnt[NC], m_div[NC], m_pend[NC], m_pdiv[NC];
    logic [NC-1:0] m_clk, m_tick;
    logic m_err;

    clkdiv_bank_if #(.NUM_CH(NC), .CNT_W(8)) bus ();

    clkdiv_bank #(
        .NUM_CH   (NC),
        .CNT_W    (8),
        .DIV_INIT ({8'd3, 8'd100, 8'd10})
    ) dut (
        .clock_1MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic legal;
        logic ld;
        int   nd;
        if (rst) begin
            m_err = 1'b0;
            for (int i = 0; i < NC; i++) begin
                m_run[i] = 0; m_cnt[i] = 0; m_div[i] = m_init[i];
                m_pend[i] = 0; m_pdiv[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
            end
        end else begin
            legal = (int'(bus.load_div_in) >= 2) && (int'(bus.load_ch_in) < NC);
            if (bus.load_in && !legal) m_err = 1'b1;
            for (int i = 0; i < NC; i++) begin
                ld = bus.load_in && legal && (int'(bus.load_ch_in) == i);
                nd = ld ? int'(bus.load_div_in) : (m_pend[i] != 0 ? m_pdiv[i] : m_div[i]);
                if (m_run[i] == 0) begin
                    if (ld) begin m_div[i] = int'(bus.load_div_in); m_pend[i] = 0; end
                    m_cnt[i] = 0;
                    m_clk[i] = bus.en_in[i];
                    m_tick[i] = bus.en_in[i];
                    m_run[i] = bus.en_in[i] ? 1 : 0;
                end else if (bus.sync_in || m_cnt[i] == m_div[i] - 1) begin
                    m_div[i] = nd; m_pend[i] = 0; m_cnt[i] = 0;
                    if (!bus.sync_in && !bus.en_in[i]) begin
                        m_run[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
                    end else begin
                        m_clk[i] = 1'b1; m_tick[i] = 1'b1;
                    end
                end else begin
                    m_cnt[i]++;
                    m_clk[i] = (m_cnt[i] < (m_div[i] + 1) / 2);
                    m_tick[i] = 1'b0;
                    if (ld) begin m_pend[i] = 1; m_pdiv[i] = int'(bus.load_div_in); end
                end
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model_step();
        e.clk = m_clk; e.tick = m_tick; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("clk_out", 32'(bus.clk_out), 32'(e.clk));
        check("tick_out", 32'(bus.tick_out), 32'(e.tick));
        check("err_out", 32'(bus.err_out), 32'(e.err));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_model_tick(input int ch);
        bit seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            step();
            if (m_tick[ch]) seen = 1;
        end
        check("align_tick", 32'(seen), 32'd1);
    endtask

    task automatic load(input int ch, input int div);
        bus.load_in = 1'b1;
        bus.load_ch_in = 2'(ch);
        bus.load_div_in = 8'(div);
        step();
        bus.load_in = 1'b0;
    endtask

    task automatic measure_period(input int ch, input int exp_n, input string tag);
        bit seen = 0;
        int n = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            step();
            if (bus.tick_out[ch]) seen = 1;
        end
        check({tag, "_first"}, 32'(seen), 32'd1);
        seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            step();
            n++;
            if (bus.tick_out[ch]) seen = 1;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        rst = 1'b1;
        bus.en_in = '0;
        bus.load_in = 1'b0;
        bus.load_ch_in = '0;
        bus.load_div_in = '0;
        bus.sync_in = 1'b0;
        steps(3);
        check("reset_clk", 32'(bus.clk_out), 32'd0);
        rst = 1'b0;
        step();

        // default divisors, first enabled cycle ticks
        bus.en_in = 3'b111;
        step();
        check("first_tick", 32'(bus.tick_out[1:0]), 32'd3);
        check("first_clk", 32'(bus.clk_out[1:0]), 32'd3);
        steps(150);
        measure_period(0, 10, "period_ch0");
        measure_period(1, 100, "period_ch1");
        measure_period(2, 3, "period_ch2");

        // odd divisor loaded mid-period on ch0
        wait_model_tick(0);
        steps(2);
        load(0, 7);
        measure_period(0, 7, "period_odd");
        steps(20);

        // glitch-free stop and re-enable
        wait_model_tick(0);
        steps(3);
        bus.en_in[0] = 1'b0;
        steps(12);
        check("stop_clk", 32'(bus.clk_out[0]), 32'd0);
        check("stop_tick", 32'(bus.tick_out[0]), 32'd0);
        load(0, 10);
        bus.en_in[0] = 1'b1;
        step();
        check("reenable_tick", 32'(bus.tick_out[0]), 32'd1);
        steps(25);

        // sync with ch1 mid-period
        wait_model_tick(1);
        steps(37);
        bus.sync_in = 1'b1;
        step();
        bus.sync_in = 1'b0;
        check("sync_tick", 32'(bus.tick_out[1:0]), 32'd3);
        steps(100);
        check("sync_coincide", 32'(bus.tick_out[1:0]), 32'd3);

        // sync coincident with enable falling
        steps(17);
        bus.en_in[1] = 1'b0;
        bus.sync_in = 1'b1;
        step();
        bus.sync_in = 1'b0;
        check("sync_fall_tick", 32'(bus.tick_out[1]), 32'd1);
        steps(100);
        check("sync_fall_stop", 32'(bus.clk_out[1]), 32'd0);

        // illegal loads
        load(0, 1);
        check("err_div", 32'(bus.err_out), 32'd1);
        load(3, 5);
        check("err_ch", 32'(bus.err_out), 32'd1);
        measure_period(0, 10, "after_illegal");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_clear", 32'(bus.err_out), 32'd0);

        // reset mid-run discards loaded divisor
        bus.en_in = 3'b010;
        step();
        load(1, 20);
        wait_model_tick(1);
        steps(13);
        rst = 1'b1;
        step();
        check("rst_clk", 32'(bus.clk_out), 32'd0);
        check("rst_tick", 32'(bus.tick_out), 32'd0);
        rst = 1'b0;
        measure_period(1, 100, "period_after_rst");

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < NC; b++)
                if ($urandom_range(0, 15) == 0) bus.en_in[b] = ~bus.en_in[b];
            bus.load_in = ($urandom_range(0, 7) == 0);
            bus.load_ch_in = 2'($urandom_range(0, 3));
            bus.load_div_in = 8'($urandom_range(0, 12));
            bus.sync_in = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.load_in = 1'b0;
        bus.sync_in = 1'b0;
        steps(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
